wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file. It sits directly downstream of the MEM/WB pipeline register. It selects the write-back value (ALU result or memory load data) under `memToReg`, commits that value into a 2^ASIZE-entry register file on the clock edge, and serves two combinational read ports to the decode stage. A same-cycle write-through bypass means decode never reads stale data for a register being written back this cycle.

## Interface
Parameters:
- `DSIZE`, default 16: data width; matches the global data-size constant.
- `ASIZE`, default 4: register address width; the file holds 2^ASIZE entries.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `WriteEn`  in  1  write enable, from MEM/WB.
- `memToReg`  in  1  write-back source select: 1 = `mem_rdata`, 0 = `alu_result`.
- `waddr`  in  ASIZE  destination register.
- `alu_result`  in  DSIZE  ALU result, from MEM/WB.
- `mem_rdata`  in  DSIZE  data-memory load data for the instruction in WB.
- `raddrA`, `raddrB`  in  ASIZE  decode-stage read addresses.
- `rdataA`, `rdataB`  out  DSIZE  read data; combinational.
- `wb_data`  out  DSIZE  selected write-back value, exported to the forwarding unit; combinational.
- `wb_valid`  out  1  high when a real write commits this cycle: `WriteEn` and `waddr` != 0 and not `rst`.

## Operation
- `wb_data` = `memToReg` ? `mem_rdata` : `alu_result`. This is a pure mux and is independent of `WriteEn`.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including through the bypass path.
- Write: at a rising edge where `wb_valid` = 1, `regs[waddr]` takes the value of `wb_data`.
- Read for each port p ∈ {A, B}, evaluated in priority order:
  - `rst` = 1 → 0.
  - `raddr_p` == 0 → 0.
  - `wb_valid` and `raddr_p` == `waddr` → `wb_data` (write-through bypass).
  - Otherwise → `regs[raddr_p]`.
- Both ports may read the same address. Both then bypass together when that address matches `waddr`.
- Reset: at a rising edge with `rst` = 1, every entry is cleared to 0 and any concurrent write is dropped. Reset dominates `WriteEn`.
- Reset mid-operation: a write pending in the same cycle as `rst` is lost. The next cycle reads all zeros.
- X handling: `mem_rdata` is only observed when `memToReg` = 1. An X on it with `memToReg` = 0 must not propagate to `wb_data`.

## Timing
- Write latency is one edge. A value presented in cycle N is visible through the array from cycle N+1, and through the bypass already in cycle N.
- Read latency: zero cycles; this is a combinational path from `raddr`.
- Critical path: `memToReg` → mux → bypass compare → `rdata`. The address compare runs in parallel with the data mux.
- Reset values:
  - All registers 0.
  - `rdataA`, `rdataB`, `wb_valid` all 0 while `rst` is high.
  - `wb_data` remains a pure mux of its inputs.
- No handshake. The stage never stalls and accepts one write per cycle unconditionally.

## Structure
- `DSIZE`, `ASIZE` and the register-count constant (1<<ASIZE) live in the shared define/package file alongside the existing stage widths.
- One natural sub-module, `regfile_core`:
  - Storage array and synchronous write/reset.
  - Two raw asynchronous read ports.
- `wb_regfile` wraps `regfile_core` with:
  - The `memToReg` mux.
  - Zero-register masking.
  - Bypass logic and `wb_valid`.
- No state machine. The only sequential state is the array itself.

## Test plan
- Reset clear: preload r1..r15 with nonzero values, assert `rst` for one edge. Required: every `raddr` reads 0; `wb_valid` = 0 during reset.
- Write/read, ALU path: `WriteEn`=1, `waddr`=5, `memToReg`=0, `alu_result`=0x1234. Required: `rdataA` at `raddrA`=5 reads 0x1234 in the same cycle (bypass) and in the following cycle (array).
- Load path with X isolation:
  - `memToReg`=1, `mem_rdata`=0xBEEF, `alu_result`=0x0001, `waddr`=7. Required: r7 = 0xBEEF.
  - Then `memToReg`=0 with `mem_rdata`=X. Required: `wb_data` is X-free.
- Register 0: write 0xFFFF to `waddr`=0 with `raddrA`=`raddrB`=0. Required: both reads 0 in the same and the next cycle; `wb_valid`=0.
- Dual-port bypass plus old value:
  - r3=0x0AAA, then write 0x0BBB to r3 with `raddrA`=`raddrB`=3. Required: both ports read 0x0BBB the same cycle.
  - With `WriteEn`=0 and the same 0x0BBB presented, a read of r3 returns the stored value, not `wb_data`.
- Reset collides with write: `rst`=1 and `WriteEn`=1, `waddr`=9, data 0x5555 in the same cycle. Required: r9 = 0 afterwards; `rdataA` = 0 during that cycle.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared widths for the write-back / register-file slice.
package wb_regfile_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int ASIZE_DEF = 4;
  localparam int REG_COUNT = 1 << ASIZE_DEF;

  function automatic int reg_count(input int asize);
    return 1 << asize;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, decode read ports, forwarding export.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) ();

  logic             WriteEn;
  logic             memToReg;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] alu_result;
  logic [DSIZE-1:0] mem_rdata;
  logic [ASIZE-1:0] raddrA;
  logic [ASIZE-1:0] raddrB;
  logic [DSIZE-1:0] rdataA;
  logic [DSIZE-1:0] rdataB;
  logic [DSIZE-1:0] wb_data;
  logic             wb_valid;

  modport master (
    output WriteEn, memToReg, waddr, alu_result, mem_rdata, raddrA, raddrB,
    input  rdataA, rdataB, wb_data, wb_valid
  );

  modport slave (
    input  WriteEn, memToReg, waddr, alu_result, mem_rdata, raddrA, raddrB,
    output rdataA, rdataB, wb_data, wb_valid
  );

endinterface

// File: rtl/regfile_core.sv
// Register storage with synchronous write/clear and two raw asynchronous read ports.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr_a,
  input  logic [ASIZE-1:0] raddr_b,
  output logic [DSIZE-1:0] rdata_a,
  output logic [DSIZE-1:0] rdata_b
);

  localparam int NREGS = reg_count(ASIZE);

  logic [DSIZE-1:0] regs [NREGS];

  // Clear has priority, so a write landing on a reset edge is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: source mux, zero-register masking and write-through bypass around regfile_core.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [DSIZE-1:0] wb_data;
  logic             wb_valid;
  logic [ASIZE-1:0] raddr [2];
  logic [DSIZE-1:0] raw   [2];
  logic [DSIZE-1:0] rdata [2];

  // Ternary on a known select keeps an X on mem_rdata away from the ALU path.
  assign wb_data  = bus.memToReg ? bus.mem_rdata : bus.alu_result;
  assign wb_valid = bus.WriteEn && (bus.waddr != '0) && !rst;

  assign raddr[0] = bus.raddrA;
  assign raddr[1] = bus.raddrB;

  regfile_core #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid),
    .waddr   (bus.waddr),
    .wdata   (wb_data),
    .raddr_a (raddr[0]),
    .raddr_b (raddr[1]),
    .rdata_a (raw[0]),
    .rdata_b (raw[1])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rdata[gi] = (rst || (raddr[gi] == '0))                ? '0      :
                         (wb_valid && (raddr[gi] == bus.waddr))    ? wb_data :
                                                                     raw[gi];
    end
  endgenerate

  assign bus.rdataA   = rdata[0];
  assign bus.rdataB   = rdata[1];
  assign bus.wb_data  = wb_data;
  assign bus.wb_valid = wb_valid;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] model [16];

  always #5 clk = ~clk;

  wb_regfile_if #(.DSIZE(16), .ASIZE(4)) bus ();

  wb_regfile #(.DSIZE(16), .ASIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [3:0] a, input logic [15:0] wbv,
                                           input logic valid);
    if (rst)                              return 16'h0;
    if (a == 4'd0)                        return 16'h0;
    if (valid && a == bus.waddr)          return wbv;
    return model[a];
  endfunction

  task automatic drive(input logic we, input logic m2r, input logic [3:0] wa,
                       input logic [15:0] alu, input logic [15:0] mem,
                       input logic [3:0] ra, input logic [3:0] rb);
    bus.WriteEn    = we;
    bus.memToReg   = m2r;
    bus.waddr      = wa;
    bus.alu_result = alu;
    bus.mem_rdata  = mem;
    bus.raddrA     = ra;
    bus.raddrB     = rb;
  endtask

  // Checks all outputs mid-cycle against the model, then advances one edge.
  task automatic cycle();
    logic [15:0] exp_wb;
    logic        exp_valid;
    @(negedge clk);
    exp_wb    = (bus.memToReg === 1'b1) ? bus.mem_rdata : bus.alu_result;
    exp_valid = !rst && bus.WriteEn && (bus.waddr != 4'd0);
    check("wb_data", bus.wb_data, exp_wb);
    check("wb_valid", {15'h0, bus.wb_valid}, {15'h0, exp_valid});
    check("rdataA", bus.rdataA, ref_read(bus.raddrA, exp_wb, exp_valid));
    check("rdataB", bus.rdataB, ref_read(bus.raddrB, exp_wb, exp_valid));
    $display("t=%0t rst=%b we=%b m2r=%b wa=%0d wb=%h ra=%0d:%h rb=%0d:%h", $time, rst,
             bus.WriteEn, bus.memToReg, bus.waddr, bus.wb_data, bus.raddrA, bus.rdataA,
             bus.raddrB, bus.rdataB);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0;
    end else if (exp_valid) begin
      model[bus.waddr] = exp_wb;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'hDEAD;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd1, 4'd2);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset clear: preload r1..r15 with nonzero values, then one reset edge.
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 16'($urandom_range(1, 16'hFFFF)), 16'h0, 4'(i), 4'(i));
      cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd4, 4'd15);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdataA", bus.rdataA, 16'h0);
    check("rst_wb_valid", {15'h0, bus.wb_valid}, 16'h0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'(i), 4'(15 - i));
      @(negedge clk);
      check("post_rst_A", bus.rdataA, 16'h0);
      check("post_rst_B", bus.rdataB, 16'h0);
      cycle();
    end

    // ALU path: bypass in the same cycle, array in the next.
    drive(1'b1, 1'b0, 4'd5, 16'h1234, 16'hFFFF, 4'd5, 4'd0);
    @(negedge clk);
    check("alu_bypass", bus.rdataA, 16'h1234);
    cycle();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd5, 4'd0);
    @(negedge clk);
    check("alu_array", bus.rdataA, 16'h1234);
    cycle();

    // Load path, then X on mem_rdata with the ALU selected.
    drive(1'b1, 1'b1, 4'd7, 16'h0001, 16'hBEEF, 4'd7, 4'd5);
    cycle();
    drive(1'b0, 1'b0, 4'd0, 16'h0042, 16'hxxxx, 4'd7, 4'd0);
    @(negedge clk);
    check("load_r7", bus.rdataA, 16'hBEEF);
    check("x_isolation", {15'h0, $isunknown(bus.wb_data)}, 16'h0);
    check("x_wb_data", bus.wb_data, 16'h0042);
    cycle();

    // Register 0 stays zero even when written.
    drive(1'b1, 1'b0, 4'd0, 16'hFFFF, 16'h0, 4'd0, 4'd0);
    @(negedge clk);
    check("r0_same_A", bus.rdataA, 16'h0);
    check("r0_same_B", bus.rdataB, 16'h0);
    check("r0_wb_valid", {15'h0, bus.wb_valid}, 16'h0);
    cycle();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 4'd0);
    @(negedge clk);
    check("r0_next_A", bus.rdataA, 16'h0);
    cycle();

    // Old value without WriteEn, then dual-port bypass.
    drive(1'b1, 1'b0, 4'd3, 16'h0AAA, 16'h0, 4'd1, 4'd2);
    cycle();
    drive(1'b0, 1'b0, 4'd3, 16'h0BBB, 16'h0, 4'd3, 4'd3);
    @(negedge clk);
    check("no_we_old_A", bus.rdataA, 16'h0AAA);
    check("no_we_old_B", bus.rdataB, 16'h0AAA);
    cycle();
    drive(1'b1, 1'b0, 4'd3, 16'h0BBB, 16'h0, 4'd3, 4'd3);
    @(negedge clk);
    check("dual_bypass_A", bus.rdataA, 16'h0BBB);
    check("dual_bypass_B", bus.rdataB, 16'h0BBB);
    cycle();

    // Reset collides with a write to r9.
    drive(1'b1, 1'b0, 4'd9, 16'h5555, 16'h0, 4'd9, 4'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_coll_A", bus.rdataA, 16'h0);
    cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd9, 4'd3);
    @(negedge clk);
    check("rst_coll_r9", bus.rdataA, 16'h0);
    check("rst_coll_r3", bus.rdataB, 16'h0);
    cycle();

    // Randomized traffic with biased address collisions and occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      drive(1'($urandom), 1'($urandom), wa, 16'($urandom), 16'($urandom),
            ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)));
      rst = ($urandom_range(0, 40) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
